wb_master_arbiter: RTL and testbench
====================================

// Module: wb_master_arbiter
// PURPOSE
//  Shares the single Wishbone master port into wb_intercon between NUM_MASTERS requesters.
//  Requesters are the core data port (wishbone_controller) and a boot/flash copy engine.
//  Round-robin arbitration; the grant is held for the whole bus cycle (cyc). The granted
//  master's signals go to the slave side; ack/err return only to the granted master.
// PARAMETERS
//  NUM_MASTERS     2    number of requesting masters, 2..4
//  TIMEOUT_CYCLES  255  stb-without-ack cycles before error (only with WB_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1       system clock
//  reset_n      in   1       asynchronous active-low reset
//  m_cyc_i      in   N       per-master cycle request
//  m_stb_i      in   N       per-master strobe
//  m_we_i       in   N       per-master write enable
//  m_adr_i      in   N*32    per-master address, master k at [32k+31:32k]
//  m_dat_i      in   N*32    per-master write data
//  m_sel_i      in   N*4     per-master byte selects
//  m_dat_o      out  32      read data, broadcast to all masters
//  m_ack_o      out  N       ack, nonzero only at the granted index
//  m_err_o      out  N       err, nonzero only at the granted index
//  s_cyc_o/s_stb_o/s_we_o  out  1   to interconnect
//  s_adr_o      out  32      to interconnect
//  s_dat_o      out  32      to interconnect
//  s_sel_o      out  4       to interconnect
//  s_cti_o      out  3       fixed 3'b000 (classic)
//  s_bte_o      out  2       fixed 2'b00
//  s_dat_i      in   32      from interconnect
//  s_ack_i      in   1       from interconnect
//  s_err_i      in   1       from interconnect
//  grant_o      out  N       one-hot current grant, 0 when idle
//  busy_o       out  1       a grant is active
// BEHAVIOUR
//  Reset (asynchronous, any state): FSM=IDLE, grant_o=0, busy_o=0, all s_* outputs=0,
//   m_ack_o=0, m_err_o=0, m_dat_o=0, priority pointer=master 0. An in-flight cycle is dropped.
//  FSM states: IDLE, BUSY, DRAIN (DRAIN exists only with the macro).
//  IDLE: if any m_cyc_i=1, register the grant for the first requester at or after the
//   pointer (wrapping). Next cycle: BUSY, and s_cyc/s_stb follow the granted master.
//   Request to s_cyc_o latency is 1 cycle.
//  BUSY: s_* = granted master's inputs; m_dat_o=s_dat_i; m_ack_o[g]=s_ack_i;
//   m_err_o[g]=s_err_i (combinational pass-through, no added latency).
//  Lock: multiple stb transfers under one continuous cyc keep the grant.
//  Leave BUSY when m_cyc_i[g]=0 (including the same cycle as the final ack):
//   go to IDLE, grant_o=0, pointer=g+1 mod N.
//  After every release there is one IDLE cycle before any new grant, even back-to-back.
//  Master drops cyc with no ack yet: abort. s_cyc/s_stb are 0 next cycle; release as above.
//  Non-granted masters: m_ack_o=m_err_o=0; their stb is ignored (they wait).
//  Simultaneous requests: strict round-robin from the pointer. No master waits more than
//   N-1 grants.
//  Idle slave side: s_cyc/s_stb/s_we=0; s_adr/s_dat/s_sel driven 0.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//   - 8..16-bit counter, cleared on ack/err or stb=0; counts while s_stb_o=1 and
//     s_ack_i=0 in BUSY.
//   - At TIMEOUT_CYCLES: m_err_o[g]=1 for exactly 1 cycle, s_cyc/s_stb=0 from that cycle.
//   - Then DRAIN until m_cyc_i[g]=0, then IDLE with pointer advanced.
//   - s_ack_i/s_err_i arriving during DRAIN are discarded.
//  WB_ARB_TIMEOUT_EN not defined: no counter, no DRAIN state. A missing ack stalls
//   indefinitely; errors come only from s_err_i.
// STRUCTURE
//  Package wb_arb_pkg: state enum arb_state_e {IDLE,BUSY,DRAIN}; WB_CTI_CLASSIC=3'b000;
//   WB_BTE_LINEAR=2'b00; MAX_MASTERS=4.
//  Sub-module rr_select: combinational; inputs req[N], pointer; outputs one-hot gnt[N] and
//   valid. Pointer register and FSM stay in the top.
// TESTING
//  1. Single request: m0 cyc/stb, adr=0x0000_2004, we=0 -> s_cyc_o 1 cycle later;
//     s_dat_i=0xCAFE_0001 with ack -> m_ack_o=2'b01, m_dat_o=0xCAFE_0001.
//  2. Tie: m0 and m1 request together from reset -> m0 granted; m0 releases, 1 idle cycle,
//     m1 granted; repeat -> m0 next.
//  3. Lock: m1 holds cyc for 3 writes to 0x0000_0100/104/108 while m0 requests -> m0 not
//     granted until m1 drops cyc; s_adr_o never shows m0's address.
//  4. Abort: m0 drops cyc before ack -> s_cyc_o=0 next cycle, grant_o=0, later ack not
//     forwarded.
//  5. Reset mid-cycle: reset_n low during BUSY -> all outputs 0 asynchronously, pointer=0.
//  6. With WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> m_err_o[g] pulses on 8th stall
//     cycle, DRAIN until cyc drops; without macro, bus stays BUSY at 100 cycles.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone master arbiter: FSM state
// encoding, fixed classic-cycle tags and a one-hot to index helper.
package wb_arb_pkg;

  localparam int MAX_MASTERS = 4;
  localparam int IDX_W       = 2;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [IDX_W-1:0] idx;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/wb_master_arbiter_if.sv
// Bundle of the requester-side and interconnect-side Wishbone signals around
// the arbiter. The master modport is the arbiter's view, slave is the environment's.
interface wb_master_arbiter_if #(
  parameter int N = 2
);

  logic [N-1:0]    m_cyc_i;
  logic [N-1:0]    m_stb_i;
  logic [N-1:0]    m_we_i;
  logic [32*N-1:0] m_adr_i;
  logic [32*N-1:0] m_dat_i;
  logic [4*N-1:0]  m_sel_i;
  logic [31:0]     m_dat_o;
  logic [N-1:0]    m_ack_o;
  logic [N-1:0]    m_err_o;

  logic            s_cyc_o;
  logic            s_stb_o;
  logic            s_we_o;
  logic [31:0]     s_adr_o;
  logic [31:0]     s_dat_o;
  logic [3:0]      s_sel_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic [31:0]     s_dat_i;
  logic            s_ack_i;
  logic            s_err_i;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
    input  s_dat_i, s_ack_i, s_err_i
  );

  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o,
    output s_dat_i, s_ack_i, s_err_i
  );

endinterface

// File: rtl/wb_master_arbiter_rr_select.sv
// Combinational round-robin picker: grants the first requester at or after
// the pointer, wrapping to the lowest index when nothing is at/above it.
module rr_select
  import wb_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  logic [N-1:0] mask;
  logic [N-1:0] hi_req;
  logic [N-1:0] pick;

  // Lowest set bit of (requests at or above ptr), else lowest set bit overall.
  always_comb begin
    mask   = ~((N'(1) << ptr) - N'(1));
    hi_req = req & mask;
    pick   = (|hi_req) ? hi_req : req;
    gnt    = pick & (~pick + N'(1));
    valid  = |req;
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between NUM_MASTERS requesters.
// Optional stall timeout with DRAIN state is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  wb_master_arbiter_if.master    bus,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   busy_o
);

  localparam int N = NUM_MASTERS;

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("wb_master_arbiter: NUM_MASTERS must be 2..4 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [N-1:0]     sel_gnt;
  logic             sel_valid;
  logic [IDX_W-1:0] g_idx;
  logic [IDX_W-1:0] ptr_next;

  logic             g_cyc, g_stb, g_we;
  logic [N:0][31:0] adr_acc, dat_acc;
  logic [N:0][3:0]  sel_acc;
  logic             to_hit;

  rr_select #(.N(N)) u_rr_select (
    .req   (bus.m_cyc_i),
    .ptr   (ptr_q),
    .gnt   (sel_gnt),
    .valid (sel_valid)
  );

  // AND-OR mux of the granted master's bus signals; zero when nothing is granted.
  assign g_cyc = |(bus.m_cyc_i & grant_q);
  assign g_stb = |(bus.m_stb_i & grant_q);
  assign g_we  = |(bus.m_we_i  & grant_q);

  assign adr_acc[0] = '0;
  assign dat_acc[0] = '0;
  assign sel_acc[0] = '0;

  for (genvar gi = 0; gi < N; gi++) begin : g_mux
    assign adr_acc[gi+1] = adr_acc[gi] | (bus.m_adr_i[32*gi +: 32] & {32{grant_q[gi]}});
    assign dat_acc[gi+1] = dat_acc[gi] | (bus.m_dat_i[32*gi +: 32] & {32{grant_q[gi]}});
    assign sel_acc[gi+1] = sel_acc[gi] | (bus.m_sel_i[4*gi +: 4]   & {4{grant_q[gi]}});
  end

  assign g_idx    = onehot_idx(MAX_MASTERS'(grant_q));
  assign ptr_next = (g_idx == IDX_W'(N - 1)) ? '0 : g_idx + 1'b1;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = 16;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  // Counter measures consecutive strobed cycles without a response; any gap clears it.
  always_comb begin
    stall  = (state_q == BUSY) && g_cyc && g_stb && !bus.s_ack_i && !bus.s_err_i;
    to_hit = stall && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d  = (stall && !to_hit) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = BUSY;
          grant_d = sel_gnt;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end else if (to_hit) begin
`ifdef WB_ARB_TIMEOUT_EN
          state_d = DRAIN;
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      DRAIN: begin
        if (!g_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Slave side follows the granted master only in BUSY; DRAIN and IDLE leave it quiet.
  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_cti_o = WB_CTI_CLASSIC;
    bus.s_bte_o = WB_BTE_LINEAR;
    bus.m_dat_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    if (state_q == BUSY) begin
      bus.s_cyc_o = g_cyc & ~to_hit;
      bus.s_stb_o = g_cyc & g_stb & ~to_hit;
      bus.s_we_o  = g_cyc & g_we;
      bus.s_adr_o = adr_acc[N];
      bus.s_dat_o = dat_acc[N];
      bus.s_sel_o = sel_acc[N];
      bus.m_dat_o = bus.s_dat_i;
      bus.m_ack_o = grant_q & {N{bus.s_ack_i}};
      bus.m_err_o = grant_q & {N{bus.s_err_i | to_hit}};
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: single transfer, tie-break, lock,
// abort, asynchronous reset mid-cycle and stall behaviour (with or without WB_ARB_TIMEOUT_EN).
module tb_wb_master_arbiter;

  localparam int N = 2;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] grant_o;
  logic         busy_o;

  int errors = 0;
  int checks = 0;

  wb_master_arbiter_if #(.N(N)) bus ();

  wb_master_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .grant_o (grant_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.s_dat_i = 32'h1234_5678;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_busy",  32'(busy_o), 32'h0);
    chk("rst_scyc",  32'(bus.s_cyc_o), 32'h0);
    chk("rst_mdat",  bus.m_dat_o, 32'h0);
    chk("rst_sadr",  bus.s_adr_o, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: single read from m0
    @(negedge clk);
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    bus.m_adr_i = {32'h0, 32'h0000_2004};
    bus.m_sel_i = 8'h03;
    #1;
    chk("t1_latency", 32'(bus.s_cyc_o), 32'h0);
    @(negedge clk); #1;
    chk("t1_scyc",  32'(bus.s_cyc_o), 32'h1);
    chk("t1_grant", 32'(grant_o), 32'h1);
    chk("t1_sadr",  bus.s_adr_o, 32'h0000_2004);
    chk("t1_ssel",  32'(bus.s_sel_o), 32'h3);
    chk("t1_swe",   32'(bus.s_we_o), 32'h0);
    bus.s_dat_i = 32'hCAFE_0001;
    bus.s_ack_i = 1'b1;
    #1;
    chk("t1_mack", 32'(bus.m_ack_o), 32'h1);
    chk("t1_mdat", bus.m_dat_o, 32'hCAFE_0001);
    @(negedge clk);
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b1;
    #1;
    chk("t1_merr", 32'(bus.m_err_o), 32'h1);
    @(negedge clk);
    bus.s_err_i = 1'b0;
    bus.m_cyc_i = 2'b00;
    bus.m_stb_i = 2'b00;
    #1;
    chk("t1_release_scyc", 32'(bus.s_cyc_o), 32'h0);
    @(negedge clk); #1;
    chk("t1_idle_grant", 32'(grant_o), 32'h0);
    chk("t1_idle_busy",  32'(busy_o), 32'h0);

    // 2: tie from reset, round-robin alternation with one idle cycle between grants
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    bus.m_cyc_i = 2'b11;
    bus.m_stb_i = 2'b11;
    bus.m_adr_i = {32'h1111_0000, 32'h0000_0010};
    @(negedge clk); #1;
    chk("t2_first_m0", 32'(grant_o), 32'h1);
    chk("t2_sadr_m0",  bus.s_adr_o, 32'h0000_0010);
    bus.m_cyc_i = 2'b10;
    bus.m_stb_i = 2'b10;
    @(negedge clk); #1;
    chk("t2_gap", 32'(grant_o), 32'h0);
    @(negedge clk); #1;
    chk("t2_then_m1", 32'(grant_o), 32'h2);
    chk("t2_sadr_m1", bus.s_adr_o, 32'h1111_0000);
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    @(negedge clk); #1;
    chk("t2_gap2", 32'(grant_o), 32'h0);
    @(negedge clk); #1;
    chk("t2_back_m0", 32'(grant_o), 32'h1);
    bus.m_cyc_i = 2'b00;
    bus.m_stb_i = 2'b00;
    @(negedge clk);

    // 3: m1 locks the bus for three writes while m0 waits
    bus.m_cyc_i = 2'b11;
    bus.m_stb_i = 2'b11;
    bus.m_we_i  = 2'b10;
    bus.m_adr_i = {32'h0000_0100, 32'hDEAD_0000};
    bus.m_dat_i = {32'hAAAA_0001, 32'h0};
    bus.m_sel_i = 8'hF3;
    #1;
    chk("t3_idle", 32'(grant_o), 32'h0);
    @(negedge clk); #1;
    chk("t3_grant_m1", 32'(grant_o), 32'h2);
    chk("t3_adr0",     bus.s_adr_o, 32'h0000_0100);
    chk("t3_we",       32'(bus.s_we_o), 32'h1);
    chk("t3_sdat",     bus.s_dat_o, 32'hAAAA_0001);
    bus.s_ack_i = 1'b1;
    #1;
    chk("t3_ack_m1_only", 32'(bus.m_ack_o), 32'h2);
    @(negedge clk);
    bus.m_adr_i = {32'h0000_0104, 32'hDEAD_0000};
    #1;
    chk("t3_adr1",  bus.s_adr_o, 32'h0000_0104);
    chk("t3_hold1", 32'(grant_o), 32'h2);
    @(negedge clk);
    bus.m_adr_i = {32'h0000_0108, 32'hDEAD_0000};
    #1;
    chk("t3_adr2",  bus.s_adr_o, 32'h0000_0108);
    chk("t3_hold2", 32'(grant_o), 32'h2);
    @(negedge clk);
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    bus.m_we_i  = 2'b00;
    #1;
    chk("t3_drop_scyc", 32'(bus.s_cyc_o), 32'h0);
    @(negedge clk); #1;
    chk("t3_gap", 32'(grant_o), 32'h0);
    @(negedge clk); #1;
    chk("t3_grant_m0", 32'(grant_o), 32'h1);
    chk("t3_adr_m0",   bus.s_adr_o, 32'hDEAD_0000);
    bus.m_cyc_i = 2'b00;
    bus.m_stb_i = 2'b00;
    @(negedge clk);

    // 4: m0 aborts before any ack; a late ack must not reach it
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    bus.m_adr_i = {32'h0, 32'h0000_2008};
    @(negedge clk); #1;
    chk("t4_grant", 32'(grant_o), 32'h1);
    chk("t4_scyc",  32'(bus.s_cyc_o), 32'h1);
    bus.m_cyc_i = 2'b00;
    bus.m_stb_i = 2'b00;
    #1;
    chk("t4_abort_scyc", 32'(bus.s_cyc_o), 32'h0);
    @(negedge clk);
    bus.s_ack_i = 1'b1;
    #1;
    chk("t4_next_scyc",  32'(bus.s_cyc_o), 32'h0);
    chk("t4_next_grant", 32'(grant_o), 32'h0);
    chk("t4_late_ack",   32'(bus.m_ack_o), 32'h0);
    @(negedge clk);
    bus.s_ack_i = 1'b0;

    // 5: asynchronous reset while m1 holds the bus
    bus.m_cyc_i = 2'b10;
    bus.m_stb_i = 2'b10;
    bus.m_adr_i = {32'h0000_3000, 32'h0};
    bus.s_dat_i = 32'h5555_AAAA;
    @(negedge clk); #1;
    chk("t5_grant_m1", 32'(grant_o), 32'h2);
    chk("t5_mdat",     bus.m_dat_o, 32'h5555_AAAA);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(grant_o), 32'h0);
    chk("t5_rst_busy",  32'(busy_o), 32'h0);
    chk("t5_rst_scyc",  32'(bus.s_cyc_o), 32'h0);
    chk("t5_rst_mdat",  bus.m_dat_o, 32'h0);
    chk("t5_rst_sadr",  bus.s_adr_o, 32'h0);
    @(negedge clk);
    reset_n     = 1'b1;
    bus.m_cyc_i = 2'b11;
    bus.m_stb_i = 2'b11;
    bus.m_adr_i = {32'h0000_3000, 32'h0000_4000};
    @(negedge clk); #1;
    chk("t5_ptr_zero", 32'(grant_o), 32'h1);
    bus.m_cyc_i = 2'b00;
    bus.m_stb_i = 2'b00;
    @(negedge clk);

    // 6: m0 strobes with no response
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    bus.m_adr_i = {32'h0, 32'h0000_5000};
    @(negedge clk); #1;
    chk("t6_grant", 32'(grant_o), 32'h1);
`ifdef WB_ARB_TIMEOUT_EN
    chk("t6_noerr_1", 32'(bus.m_err_o), 32'h0);
    repeat (6) begin
      @(negedge clk); #1;
      chk("t6_noerr", 32'(bus.m_err_o), 32'h0);
    end
    @(negedge clk); #1;
    chk("t6_err_pulse", 32'(bus.m_err_o), 32'h1);
    chk("t6_err_scyc",  32'(bus.s_cyc_o), 32'h0);
    chk("t6_err_sstb",  32'(bus.s_stb_o), 32'h0);
    @(negedge clk);
    bus.s_ack_i = 1'b1;
    #1;
    chk("t6_err_once",   32'(bus.m_err_o), 32'h0);
    chk("t6_drain_busy", 32'(busy_o), 32'h1);
    chk("t6_drain_scyc", 32'(bus.s_cyc_o), 32'h0);
    chk("t6_drain_ack",  32'(bus.m_ack_o), 32'h0);
    bus.s_ack_i = 1'b0;
    bus.m_cyc_i = 2'b00;
    bus.m_stb_i = 2'b00;
    @(negedge clk); #1;
    chk("t6_idle_busy",  32'(busy_o), 32'h0);
    chk("t6_idle_grant", 32'(grant_o), 32'h0);
`else
    repeat (99) @(negedge clk);
    #1;
    chk("t6_stall_busy",  32'(busy_o), 32'h1);
    chk("t6_stall_scyc",  32'(bus.s_cyc_o), 32'h1);
    chk("t6_stall_grant", 32'(grant_o), 32'h1);
    chk("t6_stall_noerr", 32'(bus.m_err_o), 32'h0);
    bus.m_cyc_i = 2'b00;
    bus.m_stb_i = 2'b00;
    @(negedge clk); #1;
    chk("t6_idle_busy", 32'(busy_o), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
